// File: rtl/mips_dmem_responder.sv
// Zero-wait data memory for the MIPS M-stage port, with an MMIO window (output FIFO, status, cycle counter).
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE register; otherwise CYCLE reads 0.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   ram_r  [DEPTH_WORDS];
  logic [31:0]   fifo_r [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_r;
  logic [PW:0]   rd_ptr_r;
  logic          ovf_r;
  logic          mis_r;

  logic [PW:0]   count_s;
  logic          empty_s;
  logic          full_s;
  logic          ram_sel_s;
  logic          mmio_sel_s;
  logic          st_ok_s;
  logic          mis_set_s;
  logic          ram_we_s;
  logic          out_we_s;
  logic          stat_we_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   cycle_s;

  // Address decode, FIFO occupancy and write-enable qualification.
  always_comb begin
    ram_sel_s  = ~addr[31];
    mmio_sel_s = (addr[31:4] == 28'hFFF_FFFF);
    ram_idx_s  = addr[AW+1:2];
    st_ok_s    = memwrite & (addr[1:0] == 2'b00);
    mis_set_s  = memwrite & (addr[1:0] != 2'b00);
    count_s    = wr_ptr_r - rd_ptr_r;
    empty_s    = (count_s == {(PW+1){1'b0}});
    full_s     = (count_s == FULL_COUNT);
    ram_we_s   = st_ok_s & ram_sel_s;
    out_we_s   = st_ok_s & mmio_sel_s & (addr[3:2] == 2'd0);
    stat_we_s  = st_ok_s & mmio_sel_s & (addr[3:2] == 2'd1);
    pop_s      = ~empty_s & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_s     = out_we_s & (~full_s | pop_s);
    ovf_set_s  = out_we_s & full_s & ~pop_s;
  end

  // RAM array: no reset, contents survive the reset input.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= writedata;
    end
  end

  // FIFO storage; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r[PW-1:0]] <= writedata;
    end
  end

  // FIFO pointers and sticky error flags; W1C clears lose to a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      ovf_r    <= 1'b0;
      mis_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      ovf_r <= (ovf_r & ~(stat_we_s & writedata[2])) | ovf_set_s;
      mis_r <= (mis_r & ~(stat_we_s & writedata[3])) | mis_set_s;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_r;
  logic        cyc_we_s;

  assign cyc_we_s = st_ok_s & mmio_sel_s & (addr[3:2] == 2'd2);

  // Free-running cycle counter; a store loads it instead of incrementing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r <= 32'h0000_0000;
    end else if (cyc_we_s) begin
      cycle_r <= writedata;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  assign cycle_s = cycle_r;
`else
  assign cycle_s = 32'h0000_0000;
`endif

  // Combinational read path and handshake outputs.
  always_comb begin
    readdata = 32'h0000_0000;
    if (ram_sel_s) begin
      readdata = ram_r[ram_idx_s];
    end else if (mmio_sel_s) begin
      case (addr[3:2])
        2'd0:    readdata = {{(31-PW){1'b0}}, count_s};
        2'd1:    readdata = {28'h000_0000, mis_r, ovf_r, full_s, empty_s};
        2'd2:    readdata = cycle_s;
        default: readdata = 32'h0000_0000;
      endcase
    end else begin
      readdata = 32'h0000_0000;
    end
    out_valid = ~empty_s;
    if (empty_s) begin
      out_data = 32'h0000_0000;
    end else begin
      out_data = fifo_r[rd_ptr_r[PW-1:0]];
    end
    err = ovf_r | mis_r;
  end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: per-cycle comparison against a queue/array model
// plus directed checks with literal expectations. Honours DMEM_CYCLE_COUNTER_EN if defined.
module tb_mips_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  mips_dmem_responder dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: RAM words actually written, FIFO contents, flags, counter.
  logic [31:0] mram [int];
  logic [31:0] mq [$];
  bit          m_ovf = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_cyc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge from the inputs the DUT sees.
  bit m_popped;
  bit m_cyc_loaded;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      m_cyc = 32'h0;
    end else begin
      m_popped = (mq.size() != 0) && out_ready;
      m_cyc_loaded = 1'b0;
      if (m_popped) void'(mq.pop_front());
      if (memwrite && addr[1:0] != 2'b00) begin
        m_mis = 1'b1;
      end else if (memwrite) begin
        if (!addr[31]) begin
          mram[int'(addr[7:2])] = writedata;
        end else if (addr[31:4] == 28'hFFFFFFF) begin
          case (addr[3:2])
            2'd0: if (mq.size() < 8) mq.push_back(writedata); else m_ovf = 1'b1;
            2'd1: begin
              if (writedata[2]) m_ovf = 1'b0;
              if (writedata[3]) m_mis = 1'b0;
            end
            2'd2: begin
`ifdef DMEM_CYCLE_COUNTER_EN
              m_cyc = writedata;
              m_cyc_loaded = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
`ifdef DMEM_CYCLE_COUNTER_EN
      if (!m_cyc_loaded) m_cyc = m_cyc + 32'd1;
`endif
    end
  end

  function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (!a[31]) begin
      if (!mram.exists(int'(a[7:2]))) return 1'b0;
      v = mram[int'(a[7:2])];
    end else if (a[31:4] == 28'hFFFFFFF) begin
      case (a[3:2])
        2'd0:    v = 32'(mq.size());
        2'd1:    v = {28'h0, m_mis, m_ovf, mq.size() == 8, mq.size() == 0};
        2'd2:    v = m_cyc;
        default: v = 32'h0;
      endcase
    end
    return 1'b1;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  logic [31:0] ev;
  bit          known;
  always @(negedge clk) begin
    if (!reset) begin
      known = exp_rd(addr, ev);
      if (known) chk("readdata", readdata, ev);
      chk("out_valid", {31'h0, out_valid}, {31'h0, mq.size() != 0});
      chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("err", {31'h0, err}, {31'h0, m_ovf | m_mis});
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    memwrite = 1'b1; addr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    addr = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    addr = 32'hFFFF_FFF4; #1;
    chk("rst_status", readdata, 32'h1);
    addr = 32'hFFFF_FFF8; #1;
    chk("rst_cycle", readdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // RAM store/load and aliasing
    store(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    rd("unmapped", 32'h8000_0010, 32'h0);

    // Misaligned store sets only the misalign flag
    store(32'h0000_0012, 32'h1234_5678);
    rd("mis_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("mis_status", 32'hFFFF_FFF4, 32'h9);
    chk("mis_err", {31'h0, err}, 32'h1);
    store(32'hFFFF_FFF4, 32'h8);
    rd("mis_cleared", 32'hFFFF_FFF4, 32'h1);
    chk("mis_err_clr", {31'h0, err}, 32'h0);

    // Fill past full with no consumer
    for (int i = 1; i <= 9; i++) store(32'hFFFF_FFF0, 32'(i));
    rd("fill_count", 32'hFFFF_FFF0, 32'h8);
    rd("fill_status", 32'hFFFF_FFF4, 32'h6);
    chk("fill_err", {31'h0, err}, 32'h1);

    // Drain: one word per cycle, 1..8
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("drain_data", out_data, 32'(i));
    end
    @(negedge clk);
    chk("drain_empty", {31'h0, out_valid}, 32'h0);

    // Empty FIFO: push with consumer ready appears a cycle later, then leaves
    store(32'hFFFF_FFF0, 32'h55);
    @(negedge clk);
    chk("pass_data", out_data, 32'h55);
    @(negedge clk);
    chk("pass_gone", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    store(32'hFFFF_FFF4, 32'hC);
    for (int i = 10; i <= 17; i++) store(32'hFFFF_FFF0, 32'(i));
    @(posedge clk); #1;
    memwrite = 1'b1; addr = 32'hFFFF_FFF0; writedata = 32'hAA; out_ready = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0; out_ready = 1'b0;
    rd("pp_count", 32'hFFFF_FFF0, 32'h8);
    rd("pp_status", 32'hFFFF_FFF4, 32'h2);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 11; i <= 17; i++) begin
      @(negedge clk);
      chk("pp_drain", out_data, 32'(i));
    end
    @(negedge clk);
    chk("pp_last", out_data, 32'hAA);
    @(negedge clk);
    chk("pp_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // Cycle counter load and wrap
    store(32'hFFFF_FFF8, 32'hFFFF_FFFE);
    #1;
`ifdef DMEM_CYCLE_COUNTER_EN
    chk("cyc0", readdata, 32'hFFFF_FFFE);
    @(posedge clk); #2; chk("cyc1", readdata, 32'hFFFF_FFFF);
    @(posedge clk); #2; chk("cyc2", readdata, 32'h0);
`else
    chk("cyc0", readdata, 32'h0);
    @(posedge clk); #2; chk("cyc1", readdata, 32'h0);
    @(posedge clk); #2; chk("cyc2", readdata, 32'h0);
`endif

    // Reset mid-operation: 3 entries held, overflow set
    for (int i = 20; i <= 28; i++) store(32'hFFFF_FFF0, 32'(i));
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1; out_ready = 1'b0;
    rd("pre_rst_count", 32'hFFFF_FFF0, 32'h3);
    chk("pre_rst_err", {31'h0, err}, 32'h1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd("rst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("rst_count", 32'hFFFF_FFF0, 32'h0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
